// File: rtl/dm_pkg.sv
// Shared constants and types for the data-memory access unit.
package dm_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned BE_W  = BUS_W / 8;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] MT_NONE = 2'b00;
  localparam logic [1:0] MT_BYTE = 2'b01;
  localparam logic [1:0] MT_HALF = 2'b10;
  localparam logic [1:0] MT_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_DONE = 2'b10
  } dm_state_e;

endpackage

// File: rtl/dm_access_unit_if.sv
// Data-memory req/ack bus; the access unit is the master, the memory the slave.
interface dm_access_unit_if;
  import dm_pkg::*;

  logic             req;
  logic             we;
  logic [BUS_W-1:0] addr;
  logic [BE_W-1:0]  be;
  logic [BUS_W-1:0] wdata;
  logic             ack;
  logic [BUS_W-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/dm_be_gen.sv
// Byte-enable, lane-replicated store data and alignment check for one access.
module dm_be_gen
  import dm_pkg::*;
(
  input  logic [1:0]       addr_lo,
  input  logic [1:0]       mtype,
  input  logic [BUS_W-1:0] wdata,
  output logic [BE_W-1:0]  be,
  output logic [BUS_W-1:0] wdata_rep,
  output logic             misaligned
);

  always_comb begin
    be         = '0;
    wdata_rep  = '0;
    misaligned = 1'b0;
    case (mtype)
      MT_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MT_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      MT_WORD: begin
        be         = 4'b1111;
        wdata_rep  = wdata;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage memory access controller: alignment check, one req/ack bus
// transaction per access with timeout, and a one-cycle response pulse.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [BUS_W-1:0] req_addr,
  input  logic [BUS_W-1:0] req_wdata,
  input  logic [1:0]       M_type,
  output logic             stall,
  output logic             rsp_valid,
  output logic [BUS_W-1:0] rsp_rdata,
  output logic [BUS_W-1:0] rsp_addr,
  output logic [1:0]       rsp_mtype,
  output logic             exc_adel,
  output logic             exc_ades,
  output logic             exc_bus,
  dm_access_unit_if.master bus
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  dm_state_e        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             accept, ack_done, tmo, mis_load, mis_store;
  logic             stall_c;

  logic [BE_W-1:0]  be_c;
  logic [BUS_W-1:0] wdata_rep_c;
  logic             misaligned_c;

  logic             bus_req_q, bus_we_q;
  logic [BUS_W-1:0] bus_addr_q, bus_wdata_q;
  logic [BE_W-1:0]  bus_be_q;
  logic [BUS_W-1:0] addr_q;
  logic [1:0]       mtype_q;
  logic             we_q;

  dm_be_gen u_be_gen (
    .addr_lo    (req_addr[1:0]),
    .mtype      (M_type),
    .wdata      (req_wdata),
    .be         (be_c),
    .wdata_rep  (wdata_rep_c),
    .misaligned (misaligned_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    ack_done  = 1'b0;
    tmo       = 1'b0;
    mis_load  = 1'b0;
    mis_store = 1'b0;
    stall_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && (M_type != MT_NONE)) begin
          if (misaligned_c) begin
            mis_load  = ~req_we;
            mis_store = req_we;
          end else begin
            accept  = 1'b1;
            stall_c = 1'b1;
            cnt_d   = '0;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        stall_c = 1'b1;
        // An ack in the final allowed cycle still completes the access.
        if (bus.ack) begin
          ack_done = 1'b1;
          state_d  = ST_DONE;
        end else if (cnt == TMO_LAST) begin
          tmo     = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Gated so stall is low while reset is asserted even if a request is pending.
  assign stall = stall_c & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      addr_q      <= '0;
      mtype_q     <= MT_NONE;
      we_q        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_addr    <= '0;
      rsp_mtype   <= MT_NONE;
      exc_adel    <= 1'b0;
      exc_ades    <= 1'b0;
      exc_bus     <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      rsp_valid <= ack_done;
      exc_adel  <= mis_load;
      exc_ades  <= mis_store;
      exc_bus   <= tmo;
      if (accept) begin
        bus_req_q   <= 1'b1;
        bus_we_q    <= req_we;
        bus_addr_q  <= {req_addr[BUS_W-1:2], 2'b00};
        bus_be_q    <= be_c;
        bus_wdata_q <= req_we ? wdata_rep_c : '0;
        addr_q      <= req_addr;
        mtype_q     <= M_type;
        we_q        <= req_we;
      end
      if (ack_done || tmo) bus_req_q <= 1'b0;
      if (ack_done) begin
        rsp_rdata <= we_q ? '0 : bus.rdata;
        rsp_addr  <= addr_q;
        rsp_mtype <= mtype_q;
      end
    end
  end

  assign bus.req   = bus_req_q;
  assign bus.we    = bus_we_q;
  assign bus.addr  = bus_addr_q;
  assign bus.be    = bus_be_q;
  assign bus.wdata = bus_wdata_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a response scoreboard.
module tb_dm_access_unit;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  M_type;
  logic        stall, rsp_valid, exc_adel, exc_ades, exc_bus;
  logic [31:0] rsp_rdata, rsp_addr;
  logic [1:0]  rsp_mtype;

  int nchk = 0;
  int nerr = 0;
  int nrsp = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [1:0]  mt;
  } exp_t;
  exp_t sbq[$];

  dm_access_unit_if bus ();

  dm_access_unit #(.TIMEOUT_CYC(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .M_type    (M_type),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_addr  (rsp_addr),
    .rsp_mtype (rsp_mtype),
    .exc_adel  (exc_adel),
    .exc_ades  (exc_ades),
    .exc_bus   (exc_bus),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] mt);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    M_type    = mt;
  endtask

  task automatic push(input logic [31:0] rd, input logic [31:0] a, input logic [1:0] mt);
    exp_t e;
    e.rdata = rd;
    e.addr  = a;
    e.mt    = mt;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && rsp_valid) begin
      nrsp++;
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_rdata", rsp_rdata, e.rdata);
        check("sb_addr", rsp_addr, e.addr);
        check("sb_mtype", 32'(rsp_mtype), 32'(e.mt));
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    bus.ack   = 1'b0;
    bus.rdata = 32'h0;
    next();
    next();
    check("rst_bus_req", 32'(bus.req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_exc", {29'd0, exc_adel, exc_ades, exc_bus}, 32'd0);
    check("rst_bus_addr", bus.addr, 32'd0);
    check("rst_bus_be", 32'(bus.be), 32'd0);
    reset_n = 1'b1;
    next();

    // Store byte at 0x1003, ack in cycle 1.
    drive(1'b1, 1'b1, 32'h0000_1003, 32'h0000_00A5, MT_BYTE);
    push(32'h0, 32'h0000_1003, MT_BYTE);
    settle();
    check("sb_c0_stall", 32'(stall), 32'd1);
    check("sb_c0_req", 32'(bus.req), 32'd0);
    next();
    check("sb_c1_req", 32'(bus.req), 32'd1);
    check("sb_c1_we", 32'(bus.we), 32'd1);
    check("sb_c1_addr", bus.addr, 32'h0000_1000);
    check("sb_c1_be", 32'(bus.be), 32'b1000);
    check("sb_c1_wdata", bus.wdata, 32'hA5A5_A5A5);
    check("sb_c1_stall", 32'(stall), 32'd1);
    bus.ack = 1'b1;
    next();
    bus.ack = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    settle();
    check("sb_c2_rsp", 32'(rsp_valid), 32'd1);
    check("sb_c2_stall", 32'(stall), 32'd0);
    check("sb_c2_req", 32'(bus.req), 32'd0);
    next();
    check("sb_c3_rsp", 32'(rsp_valid), 32'd0);

    // Load half at 0x2002, three wait cycles then ack.
    drive(1'b1, 1'b0, 32'h0000_2002, 32'hFFFF_FFFF, MT_HALF);
    push(32'h8001_1234, 32'h0000_2002, MT_HALF);
    next();
    check("lh_be", 32'(bus.be), 32'b1100);
    check("lh_wdata", bus.wdata, 32'h0);
    check("lh_we", 32'(bus.we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("lh_wait_req", 32'(bus.req), 32'd1);
      check("lh_wait_rsp", 32'(rsp_valid), 32'd0);
      next();
    end
    check("lh_ack_req", 32'(bus.req), 32'd1);
    bus.ack   = 1'b1;
    bus.rdata = 32'h8001_1234;
    next();
    bus.ack   = 1'b0;
    bus.rdata = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    check("lh_rsp", 32'(rsp_valid), 32'd1);
    check("lh_no_exc_bus", 32'(exc_bus), 32'd0);
    next();

    // Misaligned load word and store half.
    drive(1'b1, 1'b0, 32'h0000_3001, 32'h0, MT_WORD);
    settle();
    check("adel_c0_stall", 32'(stall), 32'd0);
    next();
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    check("adel_c1_exc", 32'(exc_adel), 32'd1);
    check("adel_c1_ades", 32'(exc_ades), 32'd0);
    check("adel_c1_req", 32'(bus.req), 32'd0);
    check("adel_c1_stall", 32'(stall), 32'd0);
    next();
    check("adel_c2_exc", 32'(exc_adel), 32'd0);
    drive(1'b1, 1'b1, 32'h0000_3003, 32'h0000_BEEF, MT_HALF);
    settle();
    check("ades_c0_stall", 32'(stall), 32'd0);
    next();
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    check("ades_c1_exc", 32'(exc_ades), 32'd1);
    check("ades_c1_adel", 32'(exc_adel), 32'd0);
    check("ades_c1_req", 32'(bus.req), 32'd0);
    next();
    check("ades_c2_exc", 32'(exc_ades), 32'd0);

    // Timeout with no ack.
    drive(1'b1, 1'b0, 32'h0000_4000, 32'h0, MT_WORD);
    next();
    for (int i = 0; i < 4; i++) begin
      check("tmo_req_hi", 32'(bus.req), 32'd1);
      check("tmo_no_exc", 32'(exc_bus), 32'd0);
      next();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    settle();
    check("tmo_req_lo", 32'(bus.req), 32'd0);
    check("tmo_exc_bus", 32'(exc_bus), 32'd1);
    check("tmo_stall", 32'(stall), 32'd0);
    check("tmo_no_rsp", 32'(rsp_valid), 32'd0);
    next();
    check("tmo_exc_clr", 32'(exc_bus), 32'd0);

    // Ack in the final allowed cycle wins over the timeout.
    drive(1'b1, 1'b1, 32'h0000_4004, 32'hDEAD_BEEF, MT_WORD);
    push(32'h0, 32'h0000_4004, MT_WORD);
    next();
    check("tack_wdata", bus.wdata, 32'hDEAD_BEEF);
    check("tack_be", 32'(bus.be), 32'b1111);
    for (int i = 0; i < 3; i++) next();
    check("tack_req", 32'(bus.req), 32'd1);
    bus.ack   = 1'b1;
    bus.rdata = 32'hCAFE_F00D;
    next();
    bus.ack = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    check("tack_rsp", 32'(rsp_valid), 32'd1);
    check("tack_no_exc", 32'(exc_bus), 32'd0);
    next();
    check("tack_exc_after", 32'(exc_bus), 32'd0);

    // Reset in the middle of a bus transaction.
    drive(1'b1, 1'b0, 32'h0000_5001, 32'h0, MT_BYTE);
    next();
    check("rmid_req", 32'(bus.req), 32'd1);
    check("rmid_be", 32'(bus.be), 32'b0010);
    #2;
    reset_n = 1'b0;
    #1;
    check("rmid_req_drop", 32'(bus.req), 32'd0);
    check("rmid_stall_drop", 32'(stall), 32'd0);
    next();
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    reset_n = 1'b1;
    bus.ack   = 1'b1;
    bus.rdata = 32'h5555_5555;
    next();
    bus.ack = 1'b0;
    check("late_ack_req", 32'(bus.req), 32'd0);
    check("late_ack_rsp", 32'(rsp_valid), 32'd0);
    next();
    check("late_ack_rsp2", 32'(rsp_valid), 32'd0);
    drive(1'b1, 1'b0, 32'h0000_6000, 32'h0, MT_WORD);
    push(32'h1234_5678, 32'h0000_6000, MT_WORD);
    next();
    check("clean_req", 32'(bus.req), 32'd1);
    check("clean_addr", bus.addr, 32'h0000_6000);
    bus.ack   = 1'b1;
    bus.rdata = 32'h1234_5678;
    next();
    bus.ack = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    check("clean_rsp", 32'(rsp_valid), 32'd1);
    next();

    // M_type none is ignored.
    drive(1'b1, 1'b1, 32'h0000_7000, 32'h1111_1111, MT_NONE);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("none_stall", 32'(stall), 32'd0);
      next();
      check("none_req", 32'(bus.req), 32'd0);
      check("none_rsp", 32'(rsp_valid), 32'd0);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, MT_NONE);
    next();
    next();

    check("sb_drain", 32'(sbq.size()), 32'd0);
    check("rsp_count", 32'(nrsp), 32'd4);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
